// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the instruction fetch stage and its PC register.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] PC_RESET = 32'h0000_0000;
  localparam logic [31:0] PC_INC   = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        vld;
  } ifid_t;

  function automatic ifid_t ifid_bubble(input logic [31:0] pc);
    ifid_t b;
    b.pc    = pc + PC_INC;
    b.instr = NOP;
    b.vld   = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter: a redirect wins over a sequential advance; otherwise the PC holds.
module pc_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic        adv_i,
  input  logic [31:0] target_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (flush_i) begin
      pc_d = target_i & ~32'h3;
    end else if (adv_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_q <= PC_RESET;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: request FSM, one-entry holding buffer for stalled acks, and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic        WritePC_i,
  input  logic        WriteIFID_i,
  input  logic        Flush_i,
  input  logic [31:0] BranchTarget_i,
  output logic        IMem_Req_o,
  output logic [31:0] IMem_Addr_o,
  input  logic        IMem_Ack_i,
  input  logic [31:0] IMem_Data_i,
  output logic [31:0] IFID_PC_o,
  output logic [31:0] IFID_Instr_o,
  output logic        IFID_Valid_o
);

  state_e      state_q, state_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  ifid_t       ifid_q, ifid_d;
  logic [31:0] pc;
  logic        pc_adv;
  logic        req;

  pc_reg u_pc_reg (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (Flush_i),
    .adv_i    (pc_adv),
    .target_i (BranchTarget_i),
    .pc_o     (pc)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    drop_addr_d = drop_addr_q;
    ifid_d      = ifid_q;
    pc_adv      = 1'b0;
    req         = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!Flush_i && start_i) state_d = S_FETCH;
      end

      S_FETCH: begin
        req = 1'b1;
        if (Flush_i) begin
          // A request left outstanding must be drained at its original address.
          ifid_d      = ifid_bubble(pc);
          drop_addr_d = pc;
          state_d     = IMem_Ack_i ? S_FETCH : S_DROP;
        end else if (IMem_Ack_i && WritePC_i && WriteIFID_i) begin
          ifid_d.pc    = pc + PC_INC;
          ifid_d.instr = IMem_Data_i;
          ifid_d.vld   = 1'b1;
          pc_adv       = 1'b1;
        end else if (IMem_Ack_i) begin
          buf_d   = IMem_Data_i;
          state_d = S_HOLD;
          if (WriteIFID_i) ifid_d = ifid_bubble(pc);
        end else if (WriteIFID_i) begin
          ifid_d = ifid_bubble(pc);
        end
      end

      S_HOLD: begin
        if (Flush_i) begin
          ifid_d  = ifid_bubble(pc);
          buf_d   = NOP;
          state_d = S_FETCH;
        end else if (WriteIFID_i) begin
          ifid_d.pc    = pc + PC_INC;
          ifid_d.instr = buf_q;
          ifid_d.vld   = 1'b1;
          pc_adv       = 1'b1;
          state_d      = S_FETCH;
        end
      end

      S_DROP: begin
        req = 1'b1;
        if (Flush_i) begin
          ifid_d = ifid_bubble(pc);
        end else if (WriteIFID_i) begin
          ifid_d = ifid_bubble(pc);
        end
        if (IMem_Ack_i) state_d = S_FETCH;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      buf_q       <= NOP;
      drop_addr_q <= PC_RESET;
      ifid_q      <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      drop_addr_q <= drop_addr_d;
      ifid_q      <= ifid_d;
    end
  end

  // While draining, the memory still sees the abandoned address; otherwise it sees the live PC.
  assign IMem_Req_o   = req;
  assign IMem_Addr_o  = (state_q == S_DROP) ? drop_addr_q : pc;
  assign IFID_PC_o    = ifid_q.pc;
  assign IFID_Instr_o = ifid_q.instr;
  assign IFID_Valid_o = ifid_q.vld;

endmodule
